// File: rtl/genius_seq_player.sv
`default_nettype none
// ============================================================================
// genius_seq_player : plays the stored colour sequence on the LEDs, one step
//                     per ON/OFF tick window, then pulses DONE.
// Revision 1.0
// ============================================================================
module genius_seq_player #(
  parameter int SIZE      = 4,
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 1
) (
  input  logic            CLKT,
  input  logic            R,
  input  logic            E,
  input  logic            START,
  input  logic [SIZE-1:0] LEVEL,
  input  logic [1:0]      SEQ_DATA,
  output logic [SIZE-1:0] SEQ_ADDR,
  output logic [3:0]      LEDS,
  output logic            BUSY,
  output logic            DONE
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SHOW = 3'd2,
    S_GAP  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [3:0]      C_ON_LAST  = 4'(ON_TICKS - 1);
  localparam logic [3:0]      C_OFF_LAST = 4'(OFF_TICKS - 1);
  localparam logic [SIZE-1:0] C_ADDR_ONE = {{(SIZE-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [SIZE-1:0] level_q, level_d;
  logic [1:0]      colour_q, colour_d;
  logic [3:0]      tick_q, tick_d;
  logic [3:0]      leds_q, leds_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  function automatic logic [3:0] decode(input logic [1:0] code);
    decode = 4'b0001 << code;
  endfunction

  always_ff @(posedge CLKT or posedge R) begin
    if (R) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      level_q  <= '0;
      colour_q <= 2'd0;
      tick_q   <= 4'd0;
      leds_q   <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      level_q  <= level_d;
      colour_q <= colour_d;
      tick_q   <= tick_d;
      leds_q   <= leds_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    level_d  = level_q;
    colour_d = colour_q;
    tick_d   = tick_q;
    leds_d   = leds_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_LOAD;
          level_d = LEVEL;
          addr_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        colour_d = SEQ_DATA;
        tick_d   = 4'd0;
        leds_d   = decode(SEQ_DATA);
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        leds_d = decode(colour_q);
        if (E) begin
          if (tick_q == C_ON_LAST) begin
            tick_d  = 4'd0;
            leds_d  = 4'd0;
            state_d = S_GAP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (E) begin
          if (tick_q == C_OFF_LAST) begin
            tick_d = 4'd0;
            if (addr_q == level_q) begin
              state_d = S_FIN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              addr_d  = addr_q + C_ADDR_ONE;
              state_d = S_LOAD;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign SEQ_ADDR = addr_q;
  assign LEDS     = leds_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_genius_seq_player.sv
`default_nettype none
// ============================================================================
// tb_genius_seq_player : randomized scoreboard bench for genius_seq_player.
// Revision 1.0
// ============================================================================
module tb_genius_seq_player;

  localparam int MAXC  = 16384;
  localparam int ON_T  = 3;
  localparam int OFF_T = 1;

  logic       CLKT = 1'b0;
  logic       R;
  logic       E;
  logic       START;
  logic [3:0] LEVEL;
  logic [1:0] SEQ_DATA;
  logic [3:0] SEQ_ADDR;
  logic [3:0] LEDS;
  logic       BUSY;
  logic       DONE;

  logic       START2;
  logic [1:0] SEQ_DATA2;
  logic [3:0] SEQ_ADDR2;
  logic [3:0] LEDS2;
  logic       BUSY2;
  logic       DONE2;

  logic [1:0] mem [0:15];
  bit         e_pat [0:MAXC-1];
  int         cyc = 0;
  int         compared = 0;
  int         mism = 0;

  typedef struct {
    int         kind;   // 0: one lit step, 1: completion pulse
    int         c0;
    int         c1;
    logic [3:0] leds;
    logic [3:0] addr;
  } ev_t;
  ev_t sbq[$];

  genius_seq_player #(.SIZE(4), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T)) dut (
    .CLKT(CLKT), .R(R), .E(E), .START(START), .LEVEL(LEVEL), .SEQ_DATA(SEQ_DATA),
    .SEQ_ADDR(SEQ_ADDR), .LEDS(LEDS), .BUSY(BUSY), .DONE(DONE)
  );

  genius_seq_player #(.SIZE(4), .ON_TICKS(1), .OFF_TICKS(1)) dut_fast (
    .CLKT(CLKT), .R(R), .E(1'b1), .START(START2), .LEVEL(4'd15), .SEQ_DATA(SEQ_DATA2),
    .SEQ_ADDR(SEQ_ADDR2), .LEDS(LEDS2), .BUSY(BUSY2), .DONE(DONE2)
  );

  always #5 CLKT = ~CLKT;
  always @(posedge CLKT) cyc <= cyc + 1;

  assign E         = (cyc < MAXC) ? e_pat[cyc] : 1'b0;
  assign SEQ_DATA  = mem[SEQ_ADDR];
  assign SEQ_DATA2 = SEQ_ADDR2[1:0] ^ 2'b10;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference timeline: each step is LOAD, then SHOW until the ON_T-th E,
  // then GAP until the OFF_T-th E; completion follows the last gap.
  function automatic int model(input int s, input int lvl);
    int  t;
    int  c;
    int  n;
    ev_t ev;
    t = s + 1;
    for (int i = 0; i <= lvl; i++) begin
      c = t;
      n = 0;
      while (n < ON_T && c < MAXC - 1) begin
        c++;
        if (e_pat[c]) n++;
      end
      ev.kind = 0; ev.c0 = t + 1; ev.c1 = c;
      ev.leds = 4'b0001 << mem[i]; ev.addr = 4'(i);
      sbq.push_back(ev);
      n = 0;
      while (n < OFF_T && c < MAXC - 1) begin
        c++;
        if (e_pat[c]) n++;
      end
      t = c + 1;
    end
    ev.kind = 1; ev.c0 = t; ev.c1 = t; ev.leds = 4'd0; ev.addr = 4'(lvl);
    sbq.push_back(ev);
    return t;
  endfunction

  // Monitor: reconstructs lit segments and DONE pulses from the pins.
  initial begin
    logic [3:0] prev_leds;
    logic [3:0] seg_leds;
    logic [3:0] seg_addr;
    int         seg_start;
    ev_t        e;
    prev_leds = 4'd0; seg_leds = 4'd0; seg_addr = 4'd0; seg_start = 0;
    forever begin
      @(negedge CLKT);
      if (R) begin
        prev_leds = 4'd0;
      end else begin
        if (LEDS != 4'd0 && prev_leds == 4'd0) begin
          seg_start = cyc; seg_leds = LEDS; seg_addr = SEQ_ADDR;
          chk("busy_while_lit", 32'(BUSY), 32'd1);
        end else if (LEDS != 4'd0) begin
          chk("leds_steady", 32'(LEDS), 32'(seg_leds));
        end else if (prev_leds != 4'd0) begin
          if (sbq.size() == 0) begin
            chk("unexpected_step", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("event_kind_step", 32'd0, 32'(e.kind));
            chk("step_leds", 32'(seg_leds), 32'(e.leds));
            chk("step_addr", 32'(seg_addr), 32'(e.addr));
            chk("step_first_cycle", 32'(seg_start), 32'(e.c0));
            chk("step_last_cycle", 32'(cyc - 1), 32'(e.c1));
          end
        end
        if (DONE) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("event_kind_done", 32'd1, 32'(e.kind));
            chk("done_cycle", 32'(cyc), 32'(e.c0));
            chk("busy_at_done", 32'(BUSY), 32'd0);
            chk("addr_at_done", 32'(SEQ_ADDR), 32'(e.addr));
          end
        end
        prev_leds = LEDS;
      end
    end
  end

  task automatic play(input int lvl, input int mode, input bit junk);
    int s;
    int d;
    @(posedge CLKT); #1;
    s = cyc;
    for (int c = s; c < s + 3000 && c < MAXC; c++) begin
      case (mode)
        0:       e_pat[c] = 1'b1;
        1:       e_pat[c] = ((c - s) % 4 == 3);
        default: e_pat[c] = ($urandom_range(0, 1) == 1);
      endcase
    end
    d = model(s, lvl);
    LEVEL = 4'(lvl);
    START = 1'b1;
    while (cyc < d + 1) begin
      @(posedge CLKT); #1;
      if (junk) begin
        START = (cyc == d) ? 1'b1 : 1'($urandom_range(0, 1));
        LEVEL = (mode == 0) ? 4'd5 : 4'($urandom_range(0, 15));
      end else begin
        START = 1'b0;
      end
    end
    START = 1'b0;
    LEVEL = 4'(lvl);
    chk("no_restart_after_done", 32'(BUSY), 32'd0);
    repeat (3) @(posedge CLKT);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic reset_mid_show();
    int s;
    int d;
    @(posedge CLKT); #1;
    s = cyc;
    for (int c = s; c < s + 200; c++) e_pat[c] = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
    d = model(s, 3);
    LEVEL = 4'd3;
    START = 1'b1;
    @(posedge CLKT); #1;
    START = 1'b0;
    while (cyc < s + 8) begin
      @(posedge CLKT); #1;
    end
    #2 R = 1'b1;
    #1;
    chk("rst_leds", 32'(LEDS), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_addr", 32'(SEQ_ADDR), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    sbq.delete();
    @(posedge CLKT); #1;
    R = 1'b0;
  endtask

  task automatic fast_run();
    int s;
    int a;
    int p;
    logic [3:0] xl;
    @(posedge CLKT); #1;
    s = cyc;
    START2 = 1'b1;
    @(posedge CLKT); #1;
    START2 = 1'b0;
    for (int k = 1; k <= 49; k++) begin
      if (k <= 48) begin
        a  = (k - 1) / 3;
        p  = (k - 1) % 3;
        xl = (p == 1) ? (4'b0001 << ((a % 4) ^ 2)) : 4'd0;
        chk("fast_addr", 32'(SEQ_ADDR2), 32'(a));
        chk("fast_leds", 32'(LEDS2), 32'(xl));
        chk("fast_busy", 32'(BUSY2), 32'd1);
        chk("fast_done_low", 32'(DONE2), 32'd0);
      end else begin
        chk("fast_done_cycle", 32'(DONE2), 32'd1);
        chk("fast_busy_fin", 32'(BUSY2), 32'd0);
        chk("fast_addr_hold", 32'(SEQ_ADDR2), 32'd15);
      end
      @(posedge CLKT); #1;
    end
    chk("fast_done_fall", 32'(DONE2), 32'd0);
  endtask

  initial begin
    R = 1'b0; START = 1'b0; START2 = 1'b0; LEVEL = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    #2 R = 1'b1;
    #1;
    chk("por_leds", 32'(LEDS), 32'd0);
    chk("por_busy", 32'(BUSY), 32'd0);
    chk("por_addr", 32'(SEQ_ADDR), 32'd0);
    chk("por_done", 32'(DONE), 32'd0);
    repeat (2) @(posedge CLKT);
    #1 R = 1'b0;

    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
    play(2, 0, 1'b0);

    mem[0] = 2'd1;
    play(0, 1, 1'b0);

    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
    play(1, 0, 1'b1);

    reset_mid_show();
    play(3, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
      play($urandom_range(0, 15), 2, 1'($urandom_range(0, 1)));
    end

    fast_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", compared, mism);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/genius_seq_player.md
# genius_seq_player

Plays the stored Genius colour sequence to the player: steps through sequence memory, lights one LED per step for a fixed number of time ticks, inserts a dark gap, then signals completion. It is the output side of a round; the player-input side and its timeout counter take over after `DONE`. Step timing uses the same slow tick enable `E` that drives the game's time counter.

## Interface
- `SIZE`, 4: width of sequence index and `LEVEL`; sequence length up to 2^SIZE.
- `ON_TICKS`, 3: `E` ticks each LED stays lit; legal range 1..15.
- `OFF_TICKS`, 1: `E` ticks of dark gap after each step; legal range 1..15.

- `CLKT` in 1: system clock, rising edge.
- `R` in 1: reset, asynchronous, active-high.
- `E` in 1: time-tick enable, one `CLKT` cycle wide per tick; may also be held high.
- `START` in 1: begin playback; sampled only in IDLE.
- `LEVEL` in SIZE: index of last step; plays `LEVEL`+1 steps; captured when `START` is accepted.
- `SEQ_DATA` in 2: colour code from sequence memory; valid one `CLKT` after `SEQ_ADDR` changes.
- `SEQ_ADDR` out SIZE: current step index into sequence memory.
- `LEDS` out 4: one-hot colour drive; code 0->0001, 1->0010, 2->0100, 3->1000; 0000 when dark.
- `BUSY` out 1: high from `START` acceptance until the DONE state.
- `DONE` out 1: one-cycle pulse after the final gap.

## Operation
- States: IDLE, LOAD, SHOW, GAP, FIN.
- IDLE: `START`=1 -> LOAD. Captures `LEVEL`. Sets `SEQ_ADDR`=0, `BUSY`=1.
- LOAD: lasts exactly one clock and ignores `E`. Registers `SEQ_DATA` into the colour register. Clears the tick counter. -> SHOW.
- SHOW: `LEDS` = decoded colour. Counts `E`=1 cycles. On the `ON_TICKS`-th counted tick -> GAP, with the tick counter cleared.
- GAP: `LEDS`=0000. Counts `E`. On the `OFF_TICKS`-th tick:
  - if `SEQ_ADDR`==captured `LEVEL` -> FIN;
  - otherwise `SEQ_ADDR`+1 -> LOAD.
- FIN: `DONE`=1, `BUSY`=0, `LEDS`=0000 for one clock -> IDLE. `SEQ_ADDR` holds its last value.
- `START` outside IDLE is ignored. A `LEVEL` change during playback has no effect.
- `E` is ignored in IDLE, LOAD and FIN.
- The tick counter is 4 bits and compares with `==`, so it never wraps within a phase.
- Reset (any state, mid-step included): state IDLE; `SEQ_ADDR`=0, `LEDS`=0000, `BUSY`=0, `DONE`=0; colour register, tick counter and captured level all 0.

## Timing
- All outputs are registered; none are combinational from inputs.
- `START` high at edge k -> from edge k: `BUSY`=1 and `SEQ_ADDR`=0.
- First LED lights after edge k+1.
- Per step with `E` held high: 1 (LOAD) + `ON_TICKS` + `OFF_TICKS` clocks.
- With sparse `E`: SHOW ends at the clock edge that samples the `ON_TICKS`-th `E` pulse; GAP ends likewise on the `OFF_TICKS`-th pulse.
- `DONE` rises at the edge after the final GAP tick and falls one clock later. `BUSY` falls at that same edge.
- A `START` on the clock where `DONE`=1 is ignored. `START` is accepted no earlier than the next cycle, in IDLE.

## Test plan
- Reset values: assert `R` asynchronously mid-cycle -> all outputs 0 immediately, with no clock edge needed.
- `E` held 1, defaults, `LEVEL`=2, memory {2,0,3}, `START` at cycle 0:
  - `LEDS`=0100 cycles 2-4, 0000 at 5;
  - 0001 cycles 7-9, 1000 cycles 12-14;
  - `DONE`=1 at cycle 16 only, `BUSY` 1 for cycles 1-15.
- `E` one pulse every 4 clocks, `LEVEL`=0, code 1:
  - `LEDS`=0010 until the 3rd `E` pulse is sampled, then dark for exactly one tick;
  - `DONE` one clock after the 4th pulse.
- `START` re-asserted during SHOW, and `LEVEL` changed to 5 mid-play with `LEVEL`=1 -> exactly 2 steps play, one `DONE`, no restart.
- `R` pulsed during the second SHOW -> `LEDS`=0000, `BUSY`=0, `SEQ_ADDR`=0.
  - A new `START` then replays from step 0.
- `ON_TICKS`=1, `OFF_TICKS`=1, `LEVEL`=15, `E`=1 -> `SEQ_ADDR` steps 0..15, 3 clocks per step, `DONE` at cycle 49.
